// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard stall unit.
//   state_e      : controller states (RUN, MEM_WAIT, FLUSH); encoding 3 unused
//   STALL_CNT_W  : width of the saturating stall statistics counter
//   WAIT_CNT_W   : width of the memory-wait cycle counter
//   FLUSH_CNT_W  : width of the branch-flush cycle counter
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam int STALL_CNT_W = 16;
  localparam int WAIT_CNT_W  = 8;
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
//   clk   : clock
//   rst   : asynchronous reset, active-high, clears count
//   inc   : increment by one this cycle (holds at all-ones)
//   clr   : synchronous clear, wins over inc
//   count : current count value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller. Resolves data-memory waits, taken-branch
// flushes and load-use dependencies (in that priority) and drives the
// pipeline enables combinationally from registered state plus current inputs.
//   clk, rst             : clock, asynchronous active-high reset
//   id_rs_addr/id_rt_addr: source registers of the decode instruction
//   id_uses_rs/id_uses_rt: decode instruction actually reads rs / rt
//   dx_mem_read          : execute instruction is a load
//   dx_rt_addr           : load destination in execute
//   xm_mem_read/write    : memory stage access request
//   mem_ready            : data memory completes the access this cycle
//   branch_taken         : branch resolved taken in execute
//   stall_b              : 0 inserts a bubble into decode/execute
//   pc_write_en          : PC update enable
//   fd_write_en          : fetch/decode register enable
//   fd_flush             : zero the fetch/decode register
//   pipe_freeze          : hold execute/memory/writeback registers
//   mem_timeout          : sticky, memory wait exceeded MEM_TIMEOUT
//   stall_count          : saturating count of stalled or frozen cycles
//   state_o              : current state encoding
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        dx_mem_read,
  input  logic [4:0]  dx_rt_addr,
  input  logic        xm_mem_read,
  input  logic        xm_mem_write,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        stall_b,
  output logic        pc_write_en,
  output logic        fd_write_en,
  output logic        fd_flush,
  output logic        pipe_freeze,
  output logic        mem_timeout,
  output logic [15:0] stall_count,
  output logic [1:0]  state_o
);

  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] ST_FLUSH    = FLUSH;

  localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]             state, state_nxt;
  logic [WAIT_CNT_W-1:0]  wait_cnt, wait_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_nxt;
  logic                   timeout_set;
  logic                   mem_req, load_use;
  logic                   run_eval, run_mem;

  always_comb begin
    mem_req  = (xm_mem_read | xm_mem_write) & ~mem_ready;
    load_use = dx_mem_read & (dx_rt_addr != 5'd0) &
               ((id_uses_rs & (id_rs_addr == dx_rt_addr)) |
                (id_uses_rt & (id_rt_addr == dx_rt_addr)));

    stall_b     = 1'b1;
    pc_write_en = 1'b1;
    fd_write_en = 1'b1;
    fd_flush    = 1'b0;
    pipe_freeze = 1'b0;
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    flush_nxt   = flush_cnt;
    timeout_set = 1'b0;
    run_eval    = 1'b0;
    run_mem     = mem_req;

    case (state)
      ST_MEM_WAIT: begin
        if (!mem_req) begin
          // Access completed or request withdrawn: behave as RUN this cycle.
          run_eval = 1'b1;
        end else if (wait_cnt >= WAIT_LIMIT) begin
          // Give up on the access; the still-pending request is masked so
          // the release cycle is not immediately re-frozen.
          timeout_set = 1'b1;
          run_eval    = 1'b1;
          run_mem     = 1'b0;
        end else begin
          pipe_freeze = 1'b1;
          pc_write_en = 1'b0;
          fd_write_en = 1'b0;
          wait_nxt    = wait_cnt + WAIT_CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (mem_req) begin
          pipe_freeze = 1'b1;
          pc_write_en = 1'b0;
          fd_write_en = 1'b0;
          state_nxt   = ST_MEM_WAIT;
          wait_nxt    = WAIT_CNT_W'(1);
          flush_nxt   = '0;
        end else begin
          // Decode holds a wrong-path instruction, so load_use is moot here.
          fd_flush = 1'b1;
          stall_b  = 1'b0;
          if (flush_cnt <= FLUSH_CNT_W'(1)) begin
            state_nxt = ST_RUN;
            flush_nxt = '0;
          end else begin
            flush_nxt = flush_cnt - FLUSH_CNT_W'(1);
          end
        end
      end
      default: run_eval = 1'b1;  // RUN, and unused encoding 3 recovers here
    endcase

    if (run_eval) begin
      state_nxt = ST_RUN;
      wait_nxt  = '0;
      flush_nxt = '0;
      if (run_mem) begin
        pipe_freeze = 1'b1;
        pc_write_en = 1'b0;
        fd_write_en = 1'b0;
        state_nxt   = ST_MEM_WAIT;
        wait_nxt    = WAIT_CNT_W'(1);
      end else if (branch_taken) begin
        // This cycle is the first flush cycle; FLUSH covers the rest.
        fd_flush = 1'b1;
        stall_b  = 1'b0;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = ST_FLUSH;
          flush_nxt = FLUSH_LOAD;
        end
      end else if (load_use) begin
        stall_b     = 1'b0;
        pc_write_en = 1'b0;
        fd_write_en = 1'b0;
      end
    end

    // Reset drives the outputs directly so they change without a clock.
    if (rst) begin
      stall_b     = 1'b0;
      pc_write_en = 1'b0;
      fd_write_en = 1'b0;
      fd_flush    = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      flush_cnt <= flush_nxt;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~stall_b | pipe_freeze),
    .clr   (1'b0),
    .count (stall_count)
  );

  assign state_o = state;

endmodule
